// File: rtl/onehot_pkg.sv
// Shared types and default widths for the one-hot scan controller slice.
package onehot_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } scan_state_e;

    localparam int DEF_BINARY_WIDTH  = 4;
    localparam int DEF_ONE_HOT_WIDTH = 16;
    localparam int DEF_DWELL_WIDTH   = 8;

endpackage

// File: rtl/onehot_next_sel.sv
// Combinational channel search over a mask: next enabled index after the
// current one (circular), wrap flag, and the lowest/highest enabled indices.
module onehot_next_sel
    import onehot_pkg::*;
#(
    parameter int BINARY_WIDTH  = DEF_BINARY_WIDTH,
    parameter int ONE_HOT_WIDTH = DEF_ONE_HOT_WIDTH
) (
    input  logic [ONE_HOT_WIDTH-1:0] mask,
    input  logic [BINARY_WIDTH-1:0]  cur_idx,
    output logic [BINARY_WIDTH-1:0]  next_idx,
    output logic                     wrap,
    output logic [BINARY_WIDTH-1:0]  lowest_idx,
    output logic [BINARY_WIDTH-1:0]  highest_idx
);

    logic [BINARY_WIDTH-1:0] above_idx;
    logic                    found_above;

    always_comb begin
        lowest_idx  = '0;
        highest_idx = '0;
        above_idx   = '0;
        found_above = 1'b0;
        // Descending walk leaves the smallest match; ascending leaves the largest.
        for (int i = ONE_HOT_WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_idx = BINARY_WIDTH'(i);
            end
            if (mask[i] && (i > int'(cur_idx))) begin
                above_idx   = BINARY_WIDTH'(i);
                found_above = 1'b1;
            end
        end
        for (int i = 0; i < ONE_HOT_WIDTH; i++) begin
            if (mask[i]) begin
                highest_idx = BINARY_WIDTH'(i);
            end
        end
        wrap     = !found_above;
        next_idx = found_above ? above_idx : lowest_idx;
    end

endmodule

// File: rtl/onehot_scan_ctrl.sv
// Scan controller: walks a latched channel mask, dwelling a programmable number
// of cycles per channel, and drives the binary select of a one-hot decoder.
module onehot_scan_ctrl
    import onehot_pkg::*;
#(
    parameter int BINARY_WIDTH  = DEF_BINARY_WIDTH,
    parameter int ONE_HOT_WIDTH = DEF_ONE_HOT_WIDTH,
    parameter int DWELL_WIDTH   = DEF_DWELL_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     continuous,
    input  logic [ONE_HOT_WIDTH-1:0] enable_mask,
    input  logic [DWELL_WIDTH-1:0]   dwell_cycles,
    output logic [BINARY_WIDTH-1:0]  sel_bin,
    output logic                     sel_valid,
    output logic                     busy,
    output logic                     scan_done,
    output logic                     err_no_channel,
    output scan_state_e              dbg_state
);

    generate
        if (ONE_HOT_WIDTH != (1 << BINARY_WIDTH)) begin : g_width_check
            $error("ONE_HOT_WIDTH must equal 2**BINARY_WIDTH");
        end
    endgenerate

    scan_state_e              state_q, state_d;
    logic [BINARY_WIDTH-1:0]  sel_q, sel_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [ONE_HOT_WIDTH-1:0] mask_q, mask_d;
    logic [DWELL_WIDTH-1:0]   dwell_q, dwell_d;
    logic                     cont_q, cont_d;
    logic [DWELL_WIDTH-1:0]   cnt_q, cnt_d;

    logic [ONE_HOT_WIDTH-1:0] search_mask;
    logic [DWELL_WIDTH-1:0]   dwell_eff;
    logic [BINARY_WIDTH-1:0]  next_idx, lowest_idx, highest_idx;
    logic                     wrap;

    // In IDLE the search looks at the live mask so the first channel is ready
    // on the start cycle; once scanning it only ever sees the latched copy.
    assign search_mask = (state_q == IDLE) ? enable_mask : mask_q;
    assign dwell_eff   = (dwell_cycles == '0) ? DWELL_WIDTH'(1) : dwell_cycles;

    onehot_next_sel #(
        .BINARY_WIDTH (BINARY_WIDTH),
        .ONE_HOT_WIDTH(ONE_HOT_WIDTH)
    ) u_next_sel (
        .mask       (search_mask),
        .cur_idx    (sel_q),
        .next_idx   (next_idx),
        .wrap       (wrap),
        .lowest_idx (lowest_idx),
        .highest_idx(highest_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                sel_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start && !stop) begin
                    if (enable_mask == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = DWELL;
                        mask_d  = enable_mask;
                        dwell_d = dwell_eff;
                        cont_d  = continuous;
                        sel_d   = lowest_idx;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = dwell_eff;
                    end
                end
            end
            DWELL: begin
                if (stop || ((cnt_q == DWELL_WIDTH'(1)) && wrap && !cont_q)) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q == DWELL_WIDTH'(1)) begin
                    sel_d = next_idx;
                    cnt_d = dwell_q;
                end else begin
                    cnt_d = cnt_q - DWELL_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered pulse: flag the coming cycle if it is the last dwell
        // cycle of the highest enabled channel.
        done_d = (state_d == DWELL) && (cnt_d == DWELL_WIDTH'(1)) && (sel_d == highest_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_bin        = sel_q;
    assign sel_valid      = valid_q;
    assign busy           = busy_q;
    assign scan_done      = done_q;
    assign err_no_channel = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_onehot_scan_ctrl.sv
// Self-checking bench for onehot_scan_ctrl: directed scenarios plus randomized
// scans compared against a per-cycle expected queue built from the scan rules.
module tb_onehot_scan_ctrl;
    import onehot_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [15:0] enable_mask;
    logic [7:0]  dwell_cycles;
    logic [3:0]  sel_bin;
    logic        sel_valid;
    logic        busy;
    logic        scan_done;
    logic        err_no_channel;
    scan_state_e dbg_state;

    int errors = 0;
    int checks = 0;

    // Each entry: {err_no_channel, busy, sel_valid, scan_done, sel_bin}
    logic [7:0] exp_q[$];

    onehot_scan_ctrl #(
        .BINARY_WIDTH (4),
        .ONE_HOT_WIDTH(16),
        .DWELL_WIDTH  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .continuous    (continuous),
        .enable_mask   (enable_mask),
        .dwell_cycles  (dwell_cycles),
        .sel_bin       (sel_bin),
        .sel_valid     (sel_valid),
        .busy          (busy),
        .scan_done     (scan_done),
        .err_no_channel(err_no_channel),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs_vec();
        return {err_no_channel, busy, sel_valid, scan_done, sel_bin};
    endfunction

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] mask, input logic [7:0] dwell, input logic cont);
        enable_mask  = mask;
        dwell_cycles = dwell;
        continuous   = cont;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Reference model: list the enabled channels in ascending order, repeat each
    // for max(dwell,1) cycles, mark the last cycle of the highest one as done.
    task automatic model_scan(input logic [15:0] mask, input logic [7:0] dwell,
                              input logic cont, input int cycles);
        int d;
        int chans[$];
        exp_q.delete();
        d = (dwell == 8'd0) ? 1 : int'(dwell);
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) chans.push_back(i);
        end
        do begin
            foreach (chans[k]) begin
                for (int j = 0; j < d; j++) begin
                    logic last;
                    last = (k == chans.size() - 1) && (j == d - 1);
                    exp_q.push_back({2'b01, 1'b1, last, 4'(chans[k])});
                end
            end
        end while (cont && exp_q.size() < cycles);
        if (cont) begin
            while (exp_q.size() > cycles) void'(exp_q.pop_back());
        end else begin
            exp_q.push_back(8'h00);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        continuous   = 1'b0;
        enable_mask  = '0;
        dwell_cycles = '0;
        tick();
        tick();
        checks++;
        if (obs_vec() !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 00", obs_vec());
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_idle: got %h want 00", obs_vec());
        end
    endtask

    task automatic test_basic_pass();
        int idx = 0;
        model_scan(16'h0025, 8'd2, 1'b0, 0);
        pulse_start(16'h0025, 8'd2, 1'b0);
        while (exp_q.size() > 0) begin
            logic [7:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL basic_pass[%0d]: got %h want %h", idx, obs_vec(), exp);
            end
            idx++;
            tick();
        end
    endtask

    task automatic test_continuous_wrap();
        int idx = 0;
        model_scan(16'h8001, 8'd0, 1'b1, 9);
        pulse_start(16'h8001, 8'd0, 1'b1);
        while (exp_q.size() > 0) begin
            logic [7:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL cont_wrap[%0d]: got %h want %h", idx, obs_vec(), exp);
            end
            idx++;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (obs_vec() !== 8'h00) begin
            errors++;
            $display("FAIL cont_wrap_stop: got %h want 00", obs_vec());
        end
    endtask

    task automatic test_empty_mask();
        pulse_start(16'h0000, 8'd3, 1'b0);
        checks++;
        if (obs_vec() !== 8'h80) begin
            errors++;
            $display("FAIL empty_mask_err: got %h want 80", obs_vec());
        end
        tick();
        checks++;
        if (obs_vec() !== 8'h00) begin
            errors++;
            $display("FAIL empty_mask_after: got %h want 00", obs_vec());
        end
    endtask

    task automatic test_single_channel();
        int idx = 0;
        model_scan(16'h0010, 8'd3, 1'b1, 10);
        pulse_start(16'h0010, 8'd3, 1'b1);
        while (exp_q.size() > 0) begin
            logic [7:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL single_chan[%0d]: got %h want %h", idx, obs_vec(), exp);
            end
            idx++;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (obs_vec() !== 8'h00) begin
            errors++;
            $display("FAIL single_chan_stop: got %h want 00", obs_vec());
        end
    endtask

    task automatic test_collisions();
        int idx = 0;
        enable_mask = 16'h00F0;
        dwell_cycles = 8'd1;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (obs_vec() !== 8'h00) begin
            errors++;
            $display("FAIL start_stop_same: got %h want 00", obs_vec());
        end
        // Scan 1,4,7; re-start and change every input mid-scan.
        model_scan(16'h0092, 8'd2, 1'b0, 0);
        pulse_start(16'h0092, 8'd2, 1'b0);
        while (exp_q.size() > 0) begin
            logic [7:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL busy_restart[%0d]: got %h want %h", idx, obs_vec(), exp);
            end
            if (idx == 1) begin
                start        = 1'b1;
                enable_mask  = 16'hFFFF;
                dwell_cycles = 8'd7;
                continuous   = 1'b1;
            end else if (idx == 2) begin
                start = 1'b0;
            end
            idx++;
            tick();
        end
    endtask

    task automatic test_reset_mid_scan();
        int idx = 0;
        model_scan(16'h0448, 8'd4, 1'b1, 5);
        pulse_start(16'h0448, 8'd4, 1'b1);
        while (exp_q.size() > 0) begin
            logic [7:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL pre_reset[%0d]: got %h want %h", idx, obs_vec(), exp);
            end
            idx++;
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 8'h00 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset: got %h state %0d want 00 state 0", obs_vec(), dbg_state);
        end
        tick();
        rst_n = 1'b1;
        tick();
        idx = 0;
        model_scan(16'h0448, 8'd1, 1'b0, 0);
        pulse_start(16'h0448, 8'd1, 1'b0);
        while (exp_q.size() > 0) begin
            logic [7:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL after_reset[%0d]: got %h want %h", idx, obs_vec(), exp);
            end
            idx++;
            tick();
        end
    endtask

    task automatic test_max_dwell();
        int idx = 0;
        model_scan(16'h0003, 8'd255, 1'b0, 0);
        pulse_start(16'h0003, 8'd255, 1'b0);
        while (exp_q.size() > 0) begin
            logic [7:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if (obs_vec() !== exp) begin
                errors++;
                $display("FAIL max_dwell[%0d]: got %h want %h", idx, obs_vec(), exp);
            end
            idx++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [15:0] mask;
            logic [7:0]  dwell;
            logic        cont;
            int          idx;
            mask  = 16'($urandom());
            if (mask == 16'h0000) mask = 16'h0001 << $urandom_range(0, 15);
            dwell = 8'($urandom_range(0, 4));
            cont  = 1'($urandom_range(0, 1));
            idx   = 0;
            model_scan(mask, dwell, cont, 24);
            pulse_start(mask, dwell, cont);
            while (exp_q.size() > 0) begin
                logic [7:0] exp;
                exp = exp_q.pop_front();
                checks++;
                if (obs_vec() !== exp) begin
                    errors++;
                    $display("FAIL random%0d[%0d] mask=%h dwell=%0d cont=%0b: got %h want %h",
                             n, idx, mask, dwell, cont, obs_vec(), exp);
                end
                idx++;
                tick();
            end
            if (cont) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                checks++;
                if (obs_vec() !== 8'h00) begin
                    errors++;
                    $display("FAIL random%0d_stop: got %h want 00", n, obs_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_continuous_wrap();
        test_empty_mask();
        test_single_channel();
        test_collisions();
        test_reset_mid_scan();
        test_max_dwell();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
